// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared FSM encoding and width helper for the UART Tx arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DRAIN   = 3'd4
  } arb_state_e;

  // Never returns less than 1 so a degenerate parameter still yields a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// rtl/uart_arb_rr_pick.sv - combinational round-robin winner search starting after last_winner
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int G_NREQ = 4
) (
  input  logic [G_NREQ-1:0]        i_req,
  input  logic [clog2(G_NREQ)-1:0] i_last_winner,
  output logic [clog2(G_NREQ)-1:0] o_winner,
  output logic                     o_any
);

  localparam int GW = clog2(G_NREQ);

  int                idx;
  logic [G_NREQ-1:0] shifted;

  // Walk offsets from farthest to nearest so the nearest requester overrides.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    idx      = 0;
    shifted  = '0;
    for (int i = G_NREQ; i >= 1; i--) begin
      idx     = (int'(i_last_winner) + i) % G_NREQ;
      shifted = i_req >> idx;
      if (shifted[0]) begin
        o_winner = GW'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter feeding one UART Tx serializer
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int G_NREQ    = 4,
  parameter int G_TIMEOUT = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [8*G_NREQ-1:0]         i_req_data,
  input  logic [G_NREQ-1:0]           i_req_valid,
  input  logic [G_NREQ-1:0]           i_req_last,
  output logic [G_NREQ-1:0]           o_req_ready,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_wr,
  input  logic                        i_tx_busy,
  output logic                        o_grant_valid,
  output logic [clog2(G_NREQ)-1:0]    o_grant,
  output logic                        o_timeout
);

  localparam int GW = clog2(G_NREQ);
  localparam int TW = clog2(G_TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [GW-1:0] last_winner_q, last_winner_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_q, last_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    rst_sync_q;
  logic          rst_n_int;
  logic [GW-1:0] pick_winner;
  logic          pick_any;
  logic          owner_valid;
  logic [7:0]    req_bytes [G_NREQ];

  // Assert immediately, release only after two clean clock edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  uart_arb_rr_pick #(.G_NREQ(G_NREQ)) u_pick (
    .i_req         (i_req_valid),
    .i_last_winner (last_winner_q),
    .o_winner      (pick_winner),
    .o_any         (pick_any)
  );

  always_comb begin
    for (int k = 0; k < G_NREQ; k++) req_bytes[k] = i_req_data[8*k +: 8];
  end

  assign owner_valid = i_req_valid[grant_q];

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      last_winner_q <= GW'(G_NREQ - 1);
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      last_winner_q <= last_winner_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    last_winner_d = last_winner_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d       = pick_winner;
          grant_valid_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_valid && !i_tx_busy) begin
          tx_data_d = req_bytes[grant_q];
          last_d    = i_req_last[grant_q];
          cnt_d     = '0;
          state_d   = ST_WRITE;
        end else if (G_TIMEOUT > 0 && !owner_valid) begin
          if (int'(cnt_q) + 1 >= G_TIMEOUT) begin
            timeout_d     = 1'b1;
            grant_valid_d = 1'b0;
            last_winner_d = grant_q;
            cnt_d         = '0;
            state_d       = ST_IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE:   state_d = ST_HOLDOFF;
      // Serializer raises busy a cycle late; this state hides that lag.
      ST_HOLDOFF: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_tx_busy) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            last_winner_d = grant_q;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_GRANT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    if (state_q == ST_GRANT && !i_tx_busy) o_req_ready[grant_q] = 1'b1;
  end

  assign o_tx_wr       = (state_q == ST_WRITE);
  assign o_tx_data     = tx_data_q;
  assign o_grant_valid = grant_valid_q;
  assign o_grant       = grant_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [7:0]  tx_data;
  logic        tx_wr, tx_busy, grant_valid, timeout;
  logic [1:0]  grant;

  uart_tx_arbiter #(.G_NREQ(4), .G_TIMEOUT(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_data    (req_data),
    .i_req_valid   (req_valid),
    .i_req_last    (req_last),
    .o_req_ready   (req_ready),
    .o_tx_data     (tx_data),
    .o_tx_wr       (tx_wr),
    .i_tx_busy     (tx_busy),
    .o_grant_valid (grant_valid),
    .o_grant       (grant),
    .o_timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mbyte [4][16];
  logic       mlast [4][16];
  int         mlen [4];
  int         mptr [4];
  logic [3:0] pending;
  int         busy_len, busy_cnt;
  logic       force_busy;
  int         n_cmp, n_fail;
  int         tick_no, timeout_seen, last_timeout_tick;
  logic [7:0] log_data [$];
  int         log_grant [$];
  int         log_tick [$];

  task automatic push(input int k, input logic [7:0] b, input logic l);
    mbyte[k][mlen[k]] = b;
    mlast[k][mlen[k]] = l;
    mlen[k]++;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      mlen[k] = 0;
      mptr[k] = 0;
    end
    pending  = '0;
    busy_cnt = 0;
    log_data.delete();
    log_grant.delete();
    log_tick.delete();
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 4; k++) begin
      if (mptr[k] < mlen[k]) begin
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = mbyte[k][mptr[k]];
        req_last[k]        = mlast[k][mptr[k]];
      end else begin
        req_valid[k]       = 1'b0;
        req_data[8*k +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
  endtask

  // One cycle: retire last cycle's handshakes, drive, then sample mid-cycle.
  task automatic tick();
    logic [3:0] own_mask;
    @(negedge clk);
    for (int k = 0; k < 4; k++) if (pending[k]) mptr[k]++;
    pending = '0;
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = force_busy;
    end
    drive_inputs();
    #1;
    tick_no++;
    if (tx_wr === 1'b1) begin
      log_data.push_back(tx_data);
      log_grant.push_back(int'(grant));
      log_tick.push_back(tick_no);
      busy_cnt = busy_len;
    end
    if (timeout === 1'b1) begin
      timeout_seen++;
      last_timeout_tick = tick_no;
    end
    if (rst_n) pending = req_valid & req_ready;
    own_mask = grant_valid ? (4'b0001 << grant) : 4'b0000;
    n_cmp++;
    if ((req_ready & ~own_mask) !== 4'b0000) begin
      n_fail++;
      $display("FAIL ready_owner_only: ready=%b owner_mask=%b tick=%0d", req_ready, own_mask, tick_no);
    end
  endtask

  task automatic run_idle(input int budget, output bit ok);
    bit done;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      done = (pending == 4'b0000) && (busy_cnt == 0) && (grant_valid === 1'b0);
      for (int k = 0; k < 4; k++) if (mptr[k] < mlen[k]) done = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    force_busy = 1'b0;
    tx_busy    = 1'b0;
    clear_model();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp += 6;
    if (tx_wr !== 1'b0)       begin n_fail++; $display("FAIL rst_tx_wr: got %b want 0", tx_wr); end
    if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_grant_valid: got %b want 0", grant_valid); end
    if (grant !== 2'd0)       begin n_fail++; $display("FAIL rst_grant: got %0d want 0", grant); end
    if (timeout !== 1'b0)     begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    if (req_ready !== 4'h0)   begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single();
    bit ok;
    int t0, bad_grant;
    do_reset();
    busy_len  = 10;
    bad_grant = 0;
    push(2, 8'h48, 1'b0);
    push(2, 8'h69, 1'b1);
    t0 = tick_no;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      run_idle(1, ok);
      if (grant_valid === 1'b1 && grant !== 2'd2) bad_grant++;
    end
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL single_timeout_budget: idle not reached"); end
    if (log_data.size() != 2) begin n_fail++; $display("FAIL single_count: got %0d want 2", log_data.size()); end
    if (bad_grant != 0) begin n_fail++; $display("FAIL single_grant_hold: got %0d off-grant cycles want 0", bad_grant); end
    if (log_data.size() == 2) begin
      n_cmp += 5;
      if (log_data[0] !== 8'h48) begin n_fail++; $display("FAIL single_byte0: got %h want 48", log_data[0]); end
      if (log_data[1] !== 8'h69) begin n_fail++; $display("FAIL single_byte1: got %h want 69", log_data[1]); end
      if (log_grant[0] != 2 || log_grant[1] != 2) begin n_fail++; $display("FAIL single_wr_grant: got %0d,%0d want 2,2", log_grant[0], log_grant[1]); end
      if (log_tick[0] - t0 != 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", log_tick[0] - t0); end
      if (log_tick[1] - log_tick[0] != 13) begin n_fail++; $display("FAIL single_spacing: got %0d want 13", log_tick[1] - log_tick[0]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_g [6];
    logic [7:0] exp_d [6];
    exp_g = '{0, 0, 1, 3, 0, 3};
    exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
    do_reset();
    busy_len = 2;
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1);
    push(3, 8'hC0, 1'b1);
    run_idle(300, ok);
    push(0, 8'hD0, 1'b1);
    push(3, 8'hE0, 1'b1);
    run_idle(300, ok);
    n_cmp++;
    if (!ok || log_data.size() != 6) begin
      n_fail++;
      $display("FAIL rr_count: got %0d bytes want 6 (idle=%0d)", log_data.size(), ok);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (log_grant[i] != exp_g[i] || log_data[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got req%0d/%h want req%0d/%h", i, log_grant[i], log_data[i], exp_g[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    bit ok;
    int exp_g [5];
    logic [7:0] exp_d [5];
    exp_g = '{1, 1, 1, 1, 0};
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h14, 8'hF0};
    clear_model();
    busy_len = 1;
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b0);
    push(1, 8'h14, 1'b1);
    tick();
    push(0, 8'hF0, 1'b1);
    run_idle(300, ok);
    n_cmp++;
    if (!ok || log_data.size() != 5) begin
      n_fail++;
      $display("FAIL hold_count: got %0d bytes want 5 (idle=%0d)", log_data.size(), ok);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (log_grant[i] != exp_g[i] || log_data[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL hold_order[%0d]: got req%0d/%h want req%0d/%h", i, log_grant[i], log_data[i], exp_g[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t_before;
    clear_model();
    busy_len = 0;
    t_before = timeout_seen;
    push(2, 8'h55, 1'b0);
    tick();
    push(3, 8'h77, 1'b1);
    for (int i = 0; i < 100 && timeout_seen == t_before; i++) tick();
    n_cmp++;
    if (timeout_seen != t_before + 1 || log_tick.size() != 1) begin
      n_fail++;
      $display("FAIL to_pulse: got %0d pulses, %0d writes want 1,1", timeout_seen - t_before, log_tick.size());
    end else begin
      n_cmp++;
      if (last_timeout_tick - log_tick[0] != 11) begin
        n_fail++;
        $display("FAIL to_delay: got %0d cycles after wr want 11", last_timeout_tick - log_tick[0]);
      end
    end
    tick();
    n_cmp += 2;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle: got %b want 0", timeout); end
    if (grant_valid !== 1'b1 || grant !== 2'd3) begin
      n_fail++;
      $display("FAIL to_handover: got gv=%b grant=%0d want 1,3", grant_valid, grant);
    end
    run_idle(100, ok);
    n_cmp++;
    if (!ok || log_data.size() != 2 || log_data[log_data.size()-1] !== 8'h77 || log_grant[log_grant.size()-1] != 3) begin
      n_fail++;
      $display("FAIL to_next_msg: got %0d bytes idle=%0d want 2 bytes ending req3/77", log_data.size(), ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_model();
    busy_len = 10;
    push(0, 8'h10, 1'b1);
    run_idle(100, ok);
    clear_model();
    push(1, 8'h21, 1'b0);
    push(1, 8'h22, 1'b1);
    for (int i = 0; i < 50 && log_data.size() == 0; i++) tick();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (tx_wr !== 1'b0)       begin n_fail++; $display("FAIL mid_tx_wr: got %b want 0", tx_wr); end
    if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
    if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_grant_valid: got %b want 0", grant_valid); end
    if (grant !== 2'd0)       begin n_fail++; $display("FAIL mid_grant: got %0d want 0", grant); end
    if (timeout !== 1'b0)     begin n_fail++; $display("FAIL mid_timeout: got %b want 0", timeout); end
    if (req_ready !== 4'h0)   begin n_fail++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
    push(0, 8'h30, 1'b1);
    push(1, 8'h31, 1'b1);
    tick();
    n_cmp++;
    if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_sync1: got gv=%b want 0", grant_valid); end
    tick();
    n_cmp++;
    if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_sync2: got gv=%b want 0", grant_valid); end
    run_idle(200, ok);
    n_cmp++;
    if (!ok || log_data.size() != 2) begin
      n_fail++;
      $display("FAIL mid_after: got %0d bytes idle=%0d want 2", log_data.size(), ok);
    end else begin
      n_cmp++;
      if (log_grant[0] != 0 || log_data[0] !== 8'h30 || log_grant[1] != 1 || log_data[1] !== 8'h31) begin
        n_fail++;
        $display("FAIL mid_order: got req%0d/%h,req%0d/%h want req0/30,req1/31", log_grant[0], log_data[0], log_grant[1], log_data[1]);
      end
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int t_before, ready_seen;
    clear_model();
    busy_len   = 0;
    force_busy = 1'b1;
    ready_seen = 0;
    t_before   = timeout_seen;
    push(2, 8'h5A, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (req_ready !== 4'h0) ready_seen++;
    end
    n_cmp += 4;
    if (log_data.size() != 0) begin n_fail++; $display("FAIL busy_no_wr: got %0d writes want 0", log_data.size()); end
    if (timeout_seen != t_before) begin n_fail++; $display("FAIL busy_no_timeout: got %0d pulses want 0", timeout_seen - t_before); end
    if (ready_seen != 0) begin n_fail++; $display("FAIL busy_ready: got %0d ready cycles want 0", ready_seen); end
    if (grant_valid !== 1'b1 || grant !== 2'd2) begin
      n_fail++;
      $display("FAIL busy_grant: got gv=%b grant=%0d want 1,2", grant_valid, grant);
    end
    force_busy = 1'b0;
    run_idle(100, ok);
    n_cmp++;
    if (!ok || log_data.size() != 1 || log_data[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL busy_release: got %0d bytes idle=%0d want 1 byte 5A", log_data.size(), ok);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    tick_no = 0;
    timeout_seen = 0;
    last_timeout_tick = 0;
    busy_len = 0;
    force_busy = 1'b0;
    rst_n = 1'b0;
    tx_busy = 1'b0;
    clear_model();
    drive_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_busy_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
